// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad BCD adder.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ADD     = 2'd2,
    RESULT  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  // Digit counters only ever need to reach 3.
  localparam int CNT_W = 2;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with carry in/out; reused serially for each digit.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  // Binary digit sum, then +6 correction when it leaves the 0..9 range.
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (raw > 5'd9);
    s    = cout ? (raw[3:0] + 4'd6) : raw[3:0];
  end

endmodule

// File: rtl/operand_sum_fsm.sv
// Keypad-driven 3-digit BCD calculator: enter A, '+', enter B, '=' -> sum.
module operand_sum_fsm
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [3:0]  key_code,
  input  logic        key_held,
  output logic [11:0] cdu,
  output logic        overflow,
  output logic [1:0]  state_dbg
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  state_e           state_q, state_d;
  logic             held_q;
  logic [11:0]      a_q, a_d;
  logic [11:0]      b_q, b_d;
  logic [11:0]      sum_q, sum_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic [1:0]       idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [11:0]      cdu_q, cdu_d;

  logic             key_evt;
  logic [3:0]       add_a, add_b, add_s;
  logic             add_cin, add_cout;

  function automatic logic [3:0] digit_at(input logic [11:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[3:0];
      2'd1:    return v[7:4];
      default: return v[11:8];
    endcase
  endfunction

  // Single digit adder, stepped units -> tens -> hundreds by idx_q.
  bcd_digit_add u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  // Next-state, operand editing and serial addition.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    key_evt = key_held & ~held_q;
    add_a   = digit_at(a_q, idx_q);
    add_b   = digit_at(b_q, idx_q);
    add_cin = (idx_q == 2'd0) ? 1'b0 : carry_q;

    case (state_q)
      ENTER_A: begin
        if (key_evt) begin
          if (is_digit(key_code)) begin
            if (cnt_a_q < MAX_CNT) begin
              a_d     = {a_q[7:0], key_code};
              cnt_a_d = cnt_a_q + 1'b1;
            end
          end else if (key_code == KEY_ADD) begin
            state_d = ENTER_B;
            b_d     = '0;
            cnt_b_d = '0;
          end
        end
      end
      ENTER_B: begin
        if (key_evt) begin
          if (is_digit(key_code)) begin
            if (cnt_b_q < MAX_CNT) begin
              b_d     = {b_q[7:0], key_code};
              cnt_b_d = cnt_b_q + 1'b1;
            end
          end else if (key_code == KEY_EQ) begin
            state_d = ADD;
            idx_d   = 2'd0;
            carry_d = 1'b0;
          end
        end
      end
      ADD: begin
        case (idx_q)
          2'd0:    sum_d[3:0]  = add_s;
          2'd1:    sum_d[7:4]  = add_s;
          default: sum_d[11:8] = add_s;
        endcase
        carry_d = add_cout;
        if (idx_q == 2'd2) begin
          state_d = RESULT;
          ovf_d   = add_cout;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      RESULT: begin
        if (key_evt) begin
          if (is_digit(key_code)) begin
            state_d = ENTER_A;
            a_d     = {8'h00, key_code};
            cnt_a_d = CNT_W'(1);
            b_d     = '0;
            cnt_b_d = '0;
            ovf_d   = 1'b0;
          end else if (key_code == KEY_ADD) begin
            state_d = ENTER_B;
            a_d     = sum_q;
            cnt_a_d = MAX_CNT;
            b_d     = '0;
            cnt_b_d = '0;
            ovf_d   = 1'b0;
          end
        end
      end
      default: state_d = ENTER_A;
    endcase

    // Clear wins over everything except an addition in flight.
    if (key_evt && (key_code == KEY_CLR) && (state_q != ADD)) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      sum_d   = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end

    case (state_d)
      ENTER_A: cdu_d = a_d;
      RESULT:  cdu_d = sum_d;
      default: cdu_d = b_d;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ENTER_A;
      held_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cdu_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= key_held;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cdu_q   <= cdu_d;
    end
  end

  assign cdu       = cdu_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_operand_sum_fsm.sv
// Scoreboard bench for operand_sum_fsm with a decimal-arithmetic reference model.
module tb_operand_sum_fsm;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_held = 1'b0;
  logic [11:0] cdu;
  logic        overflow;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] cdu;
    logic        ovf;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: operands and result as plain decimal integers.
  int m_a, m_b, m_res, m_cnt_a, m_cnt_b, m_mode;
  bit m_ovf;

  operand_sum_fsm #(.MAX_DIGITS(3)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .key_code  (key_code),
    .key_held  (key_held),
    .cdu       (cdu),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_cnt_a = 0; m_cnt_b = 0; m_mode = 0; m_ovf = 0;
  endfunction

  function automatic void model_apply(input int code);
    if (code == 14 && m_mode != 2) begin
      model_reset();
    end else if (code <= 9) begin
      if (m_mode == 0 && m_cnt_a < 3) begin
        m_a = m_a * 10 + code; m_cnt_a++;
      end else if (m_mode == 1 && m_cnt_b < 3) begin
        m_b = m_b * 10 + code; m_cnt_b++;
      end else if (m_mode == 3) begin
        m_a = code; m_cnt_a = 1; m_b = 0; m_cnt_b = 0; m_ovf = 0; m_mode = 0;
      end
    end else if (code == 10) begin
      if (m_mode == 0) begin
        m_b = 0; m_cnt_b = 0; m_mode = 1;
      end else if (m_mode == 3) begin
        m_a = m_res; m_cnt_a = 3; m_b = 0; m_cnt_b = 0; m_ovf = 0; m_mode = 1;
      end
    end else if (code == 15 && m_mode == 1) begin
      m_res = (m_a + m_b) % 1000;
      m_ovf = (m_a + m_b) > 999;
      m_mode = 3;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.cdu = (m_mode == 0) ? to_bcd(m_a) : (m_mode == 3) ? to_bcd(m_res) : to_bcd(m_b);
    e.ovf = m_ovf;
    e.st  = 2'(m_mode);
    return e;
  endfunction

  task automatic push_expect();
    exp_q.push_back(model_out());
  endtask

  // Monitor: outputs are stable whenever an expectation is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cdu", int'(cdu), int'(e.cdu));
      chk("overflow", int'(overflow), int'(e.ovf));
      chk("state", int'(state_dbg), int'(e.st));
    end
  end

  task automatic press(input int code, input int hold);
    @(posedge clk); #2;
    key_code = 4'(code);
    key_held = 1'b1;
    repeat (hold) @(posedge clk);
    #2;
    key_held = 1'b0;
    key_code = 4'($urandom);
    repeat (6) @(posedge clk);
    #2;
    model_apply(code);
    push_expect();
  endtask

  task automatic press_seq(input int codes[$]);
    foreach (codes[i]) press(codes[i], 1);
  endtask

  // '=' with cycle-accurate check of the ADD window.
  task automatic eq_timed();
    exp_t e;
    @(posedge clk); #2;
    key_code = 4'hF;
    key_held = 1'b1;
    @(posedge clk); #1;
    chk("eq_edge1_state", int'(state_dbg), 2);
    #1 key_held = 1'b0;
    @(posedge clk); #1;
    chk("eq_edge2_state", int'(state_dbg), 2);
    @(posedge clk); #1;
    chk("eq_edge3_state", int'(state_dbg), 2);
    @(posedge clk); #1;
    model_apply(15);
    e = model_out();
    chk("eq_edge4_state", int'(state_dbg), 3);
    chk("eq_edge4_cdu", int'(cdu), int'(e.cdu));
    chk("eq_edge4_ovf", int'(overflow), int'(e.ovf));
    repeat (2) @(posedge clk);
    #2 push_expect();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, code;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #5;
    chk("rst_cdu", int'(cdu), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_state", int'(state_dbg), 0);
    @(posedge clk); #2 n_reset = 1'b1;

    // 123 + 456
    press_seq('{1, 2, 3, 10, 4, 5, 6});
    eq_timed();

    // 999 + 001 overflow, then clear
    press_seq('{14, 9, 9, 9, 10, 0, 0, 1});
    eq_timed();
    press(14, 1);

    // Digit limit and long hold
    press_seq('{4, 5, 6, 7});
    press(14, 1);
    press(3, 50);

    // Chain from result
    press_seq('{14, 1, 5, 10, 2, 7, 15, 10, 8, 15});

    // Ignored keys
    press_seq('{14, 5, 15, 11, 12, 13, 10, 11, 12, 13, 2, 15, 11, 12, 13, 15});

    // Digit during ADD is discarded
    press_seq('{14, 1, 2, 10, 3});
    @(posedge clk); #2 key_code = 4'hF; key_held = 1'b1;
    @(posedge clk); #2 key_held = 1'b0;
    @(posedge clk); #2 key_code = 4'h5; key_held = 1'b1;
    @(posedge clk); #2 key_held = 1'b0;
    repeat (6) @(posedge clk);
    #2 model_apply(15);
    push_expect();

    // Asynchronous reset in the middle of ADD
    press_seq('{10, 4});
    @(posedge clk); #2 key_code = 4'hF; key_held = 1'b1;
    @(posedge clk); #2 key_held = 1'b0;
    @(posedge clk); #2 n_reset = 1'b0;
    #1;
    chk("midadd_rst_cdu", int'(cdu), 0);
    chk("midadd_rst_state", int'(state_dbg), 0);
    chk("midadd_rst_ovf", int'(overflow), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 n_reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 push_expect();

    // Random key sequences
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 13);
      code = (r < 8) ? $urandom_range(0, 9) : $urandom_range(10, 15);
      press(code, $urandom_range(1, 4));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) chk("scoreboard_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_sum_fsm.md
OPERAND_SUM_FSM -- requirements
Module: operand_sum_fsm

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 3, meaning the BCD digits per operand; only the value 3 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port n_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port key_code, input, 4 bits: debounced key code from the keypad scanner; valid only while key_held=1.
REQ-005 The block SHALL have port key_held, input, 1 bit: level, high while a key is debounced-pressed.
REQ-006 The block SHALL have port cdu, output, 12 bits: BCD hundreds[11:8], tens[7:4], units[3:0] driving the display mux/decoder.
REQ-007 The block SHALL have port overflow, output, 1 bit: high while the displayed result exceeded 999.
REQ-008 The block SHALL have port state_dbg, output, 2 bits: current FSM state encoding, for debug LEDs.

Function
REQ-009 The block SHALL register key_held and SHALL generate one key event on the cycle where key_held=1 and the registered copy is 0; it SHALL sample key_code on that same cycle.
REQ-010 Key decoding SHALL be: 0x0-0x9 digit, 0xA add, 0xE clear, 0xF equals; 0xB-0xD SHALL be ignored.
REQ-011 The FSM SHALL have states ENTER_A, ENTER_B, ADD, RESULT.
REQ-012 In ENTER_A or ENTER_B, a digit event SHALL shift the operand left one digit, inserting the new digit as units, only while fewer than 3 digits are entered; further digits SHALL be ignored.
REQ-013 A leading 0 SHALL count as an entered digit.
REQ-014 An add event in ENTER_A SHALL go to ENTER_B with operand B and its digit count cleared.
REQ-015 An add event in ENTER_B or ENTER_A->ENTER_B transitions SHALL NOT alter operand A.
REQ-016 An equals event in ENTER_B SHALL go to ADD. An equals event in ENTER_A SHALL be ignored.
REQ-017 ADD SHALL last exactly 3 cycles and add one BCD digit per cycle, units first, propagating carry.
REQ-018 Each digit sum greater than 9 SHALL be corrected by +6 with carry-out 1.
REQ-019 On the 4th rising edge after the equals event, the state SHALL be RESULT, and cdu SHALL hold the 3-digit sum.
REQ-020 In RESULT, overflow SHALL equal the final carry, i.e. the true sum of 1000-1998 shows sum-1000.
REQ-021 Key events arriving during ADD SHALL be discarded.
REQ-022 In RESULT, a digit event SHALL clear both operands and overflow, then go to ENTER_A with that digit as the first digit of A.
REQ-023 In RESULT, an add event SHALL load A with the result, clear B and overflow, and go to ENTER_B.
REQ-024 In RESULT, an equals event SHALL be ignored.
REQ-025 A clear event in any state except ADD SHALL zero A, B, digit counts, and overflow, then go to ENTER_A.
REQ-026 cdu SHALL show A in ENTER_A, B in ENTER_B, and the sum in RESULT; during ADD it SHALL hold B.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While n_reset=0, the state SHALL be ENTER_A, and A, B, sum, digit counts, and carry SHALL be 0.
REQ-029 While n_reset=0, the key_held register SHALL be 0, cdu SHALL be 0x000, overflow SHALL be 0, and state_dbg SHALL be 2'b00.
REQ-030 Reset asserted during ADD SHALL abort the addition with no partial result visible after release.
REQ-031 If key_held is already 1 at reset release, that SHALL count as an event on the first clock; this is accepted behaviour.

Structure
REQ-032 Package calc_pkg SHALL hold the state enum (ENTER_A=0, ENTER_B=1, ADD=2, RESULT=3), the key-code constants KEY_ADD, KEY_CLR, and KEY_EQ, and the digit-count width.
REQ-033 A combinational sub-module bcd_digit_add (a[3:0], b[3:0], cin -> s[3:0], cout) SHALL be instantiated once and time-multiplexed across the 3 ADD cycles.

Verification
REQ-034 Scenario: after reset, keys 1,2,3 then 0xA then 4,5,6 then 0xF -> after the 0xF edge plus 4 clocks, cdu=0x579, overflow=0, state_dbg=3.
REQ-035 Scenario: operands 999 + 001 -> cdu=0x000, overflow=1; then key 0xE -> cdu=0x000, overflow=0, state_dbg=0.
REQ-036 Scenario: keys 4,5,6,7 -> cdu=0x456; a held key spanning 50 clocks produces a single digit.
REQ-037 Scenario: 15+27 '=' (cdu=0x042), then 0xA, 8, '=' -> cdu=0x050 (chain from result).
REQ-038 Scenario: digit pressed during the ADD cycles is ignored; n_reset pulsed low mid-ADD -> cdu=0x000 and state ENTER_A asynchronously, before the next clock edge.
REQ-039 Scenario: key 0xF in ENTER_A, and keys 0xB-0xD in any state -> no change to cdu or state.
